ysyx_25040111_trap_seq: RTL and testbench

- Sequencer and arbiter in front of the single-port machine CSR file (one write port, one combinational read port).
- Shares that port between the EXU's Zicsr instruction accesses and trap entry/exit sequencing (ecall, mret).
- Entry and exit are multi-cycle read-modify-write sequences; each ends with a one-cycle PC redirect pulse to the IFU.

---
 rtl/ysyx_25040111_trap_seq.sv | 208 ++++++++++++++++++++
 tb/tb_ysyx_25040111_trap_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_trap_seq.sv
// ysyx_25040111_trap_seq
//
// Sequencer and arbiter in front of the single-port machine CSR file. The one write port and
// one combinational read port are shared between EXU Zicsr accesses and the multi-cycle
// trap entry (ecall) / exit (mret) read-modify-write sequences. Each sequence finishes
// with a one-cycle PC redirect pulse to the IFU.
//
// Optional feature macro: YSYX_TRAP_SEQ_VECTORED_EN
//   defined   : mtvec.MODE = 01 with an interrupt cause vectors to base + 4*cause.
//   undefined : the trap target is always the mtvec base; mtvec[1:0] is ignored.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   ins_*              EXU CSR access request (valid/ready, wen, ren, addr, wdata, rdata)
//   trap_*             trap request (valid/ready, kind 0=ecall 1=mret, pc, cause)
//   redirect_valid_o   one-cycle redirect pulse, redirect_pc_o is the new PC
//   busy_o             a trap sequence is in progress
//   csr_*              CSR file port (write: wen/waddr/wdata, read: ren/raddr/rdata)

module ysyx_25040111_trap_seq #(
    parameter int unsigned XLEN    = 32,
    parameter logic [1:0]  MPP_VAL = 2'b11
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            ins_valid_i,
    output logic            ins_ready_o,
    input  logic            ins_wen_i,
    input  logic            ins_ren_i,
    input  logic [11:0]     ins_addr_i,
    input  logic [XLEN-1:0] ins_wdata_i,
    output logic [XLEN-1:0] ins_rdata_o,

    input  logic            trap_valid_i,
    output logic            trap_ready_o,
    input  logic            trap_kind_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,

    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o,

    output logic            csr_wen_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            csr_ren_o,
    output logic [11:0]     csr_raddr_o,
    input  logic [XLEN-1:0] csr_rdata_i
);

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMtvec   = 12'h305;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;

    typedef enum logic [2:0] {
        StIdle,
        StEEpc,
        StECause,
        StEStat,
        StEVec,
        StMStat,
        StMEpc,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] target_q, target_d;

    // mstatus images derived from the value currently on the read port.
    logic [XLEN-1:0] mstatus_entry;
    logic [XLEN-1:0] mstatus_mret;
    logic [XLEN-1:0] vec_base;

    always_comb begin
        mstatus_entry        = csr_rdata_i;
        mstatus_entry[7]     = csr_rdata_i[3];
        mstatus_entry[3]     = 1'b0;
        mstatus_entry[12:11] = MPP_VAL;

        mstatus_mret         = csr_rdata_i;
        mstatus_mret[3]      = csr_rdata_i[7];
        mstatus_mret[7]      = 1'b1;
        mstatus_mret[12:11]  = MPP_VAL;

        vec_base             = {csr_rdata_i[XLEN-1:2], 2'b00};
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        cause_d          = cause_q;
        target_d         = target_q;

        ins_ready_o      = 1'b0;
        ins_rdata_o      = '0;
        trap_ready_o     = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        busy_o           = 1'b0;
        csr_wen_o        = 1'b0;
        csr_waddr_o      = '0;
        csr_wdata_o      = '0;
        csr_ren_o        = 1'b0;
        csr_raddr_o      = '0;

        // While reset is held every request and CSR strobe is suppressed, so an in-flight
        // sequence cannot commit another write on the reset edge.
        if (!reset) begin
            busy_o = (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    trap_ready_o = 1'b1;
                    if (trap_valid_i) begin
                        // Trap wins; a pending instruction is re-granted after the sequence.
                        pc_d    = trap_pc_i;
                        cause_d = trap_cause_i;
                        state_d = trap_kind_i ? StMStat : StEEpc;
                    end else if (ins_valid_i) begin
                        ins_ready_o = 1'b1;
                        csr_wen_o   = ins_wen_i;
                        csr_waddr_o = ins_addr_i;
                        csr_wdata_o = ins_wdata_i;
                        csr_ren_o   = ins_ren_i;
                        csr_raddr_o = ins_addr_i;
                        ins_rdata_o = csr_rdata_i;
                    end
                end
                StEEpc: begin
                    csr_wen_o   = 1'b1;
                    csr_waddr_o = CsrMepc;
                    csr_wdata_o = pc_q;
                    state_d     = StECause;
                end
                StECause: begin
                    csr_wen_o   = 1'b1;
                    csr_waddr_o = CsrMcause;
                    csr_wdata_o = cause_q;
                    state_d     = StEStat;
                end
                StEStat: begin
                    csr_ren_o   = 1'b1;
                    csr_raddr_o = CsrMstatus;
                    csr_wen_o   = 1'b1;
                    csr_waddr_o = CsrMstatus;
                    csr_wdata_o = mstatus_entry;
                    state_d     = StEVec;
                end
                StEVec: begin
                    csr_ren_o   = 1'b1;
                    csr_raddr_o = CsrMtvec;
`ifdef YSYX_TRAP_SEQ_VECTORED_EN
                    // Vectored mode for interrupts: 4*cause, with the sum wrapping at XLEN.
                    if (csr_rdata_i[1:0] == 2'b01 && cause_q[XLEN-1]) begin
                        target_d = vec_base + {cause_q[XLEN-3:0], 2'b00};
                    end else begin
                        target_d = vec_base;
                    end
`else
                    target_d    = vec_base;
`endif
                    state_d     = StDone;
                end
                StMStat: begin
                    csr_ren_o   = 1'b1;
                    csr_raddr_o = CsrMstatus;
                    csr_wen_o   = 1'b1;
                    csr_waddr_o = CsrMstatus;
                    csr_wdata_o = mstatus_mret;
                    state_d     = StMEpc;
                end
                StMEpc: begin
                    csr_ren_o   = 1'b1;
                    csr_raddr_o = CsrMepc;
                    target_d    = csr_rdata_i;
                    state_d     = StDone;
                end
                StDone: begin
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = target_q;
                    state_d          = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_trap_seq.sv
module tb_ysyx_25040111_trap_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic        ins_wen = 1'b0;
    logic        ins_ren = 1'b0;
    logic [11:0] ins_addr = '0;
    logic [31:0] ins_wdata = '0;
    logic [31:0] ins_rdata;
    logic        trap_valid = 1'b0;
    logic        trap_ready;
    logic        trap_kind = 1'b0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_cause = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_ren;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;

    ysyx_25040111_trap_seq #(
        .XLEN    (32),
        .MPP_VAL (2'b11)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ins_valid_i      (ins_valid),
        .ins_ready_o      (ins_ready),
        .ins_wen_i        (ins_wen),
        .ins_ren_i        (ins_ren),
        .ins_addr_i       (ins_addr),
        .ins_wdata_i      (ins_wdata),
        .ins_rdata_o      (ins_rdata),
        .trap_valid_i     (trap_valid),
        .trap_ready_o     (trap_ready),
        .trap_kind_i      (trap_kind),
        .trap_pc_i        (trap_pc),
        .trap_cause_i     (trap_cause),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .busy_o           (busy),
        .csr_wen_o        (csr_wen),
        .csr_waddr_o      (csr_waddr),
        .csr_wdata_o      (csr_wdata),
        .csr_ren_o        (csr_ren),
        .csr_raddr_o      (csr_raddr),
        .csr_rdata_i      (csr_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // CSR index: bit 2 set means "not a modelled CSR".
    function automatic logic [2:0] csr_idx(input logic [11:0] a);
        case (a)
            12'h300: return 3'd0;
            12'h305: return 3'd1;
            12'h341: return 3'd2;
            12'h342: return 3'd3;
            default: return 3'b100;
        endcase
    endfunction

    // Environment CSR file: combinational read, write at the clock edge, not reset.
    logic [31:0] csrf [4];
    logic [2:0]  rd_idx, wr_idx;
    assign rd_idx = csr_idx(csr_raddr);
    assign wr_idx = csr_idx(csr_waddr);
    assign csr_rdata = (csr_ren && !rd_idx[2]) ? csrf[rd_idx[1:0]] : 32'h0;
    always @(posedge clk) begin
        if (csr_wen && !wr_idx[2]) csrf[wr_idx[1:0]] <= csr_wdata;
    end

    // Reference model of architectural CSR contents (0 mstatus, 1 mtvec, 2 mepc, 3 mcause).
    logic [31:0] m_csr [4];

    function automatic logic [31:0] model_entry(input logic [31:0] s);
        logic [31:0] r;
        r = (s & ~32'h0000_1888) | 32'h0000_1800;
        if ((s & 32'h8) != 0) r = r | 32'h80;
        return r;
    endfunction

    function automatic logic [31:0] model_mret(input logic [31:0] s);
        logic [31:0] r;
        r = (s & ~32'h0000_1888) | 32'h0000_1800 | 32'h80;
        if ((s & 32'h80) != 0) r = r | 32'h8;
        return r;
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] tv, input logic [31:0] c);
        logic [31:0] base;
        base = tv & ~32'h3;
`ifdef YSYX_TRAP_SEQ_VECTORED_EN
        if ((tv & 32'h3) == 32'h1 && c >= 32'h8000_0000) return base + (c - 32'h8000_0000) * 4;
`endif
        return base + 32'h0 * c;
    endfunction

    typedef struct {
        logic [31:0] pc;
        int          due;
    } redir_t;

    redir_t      redir_q[$];
    logic [31:0] rd_q[$];

    // Monitor: pops expectations whenever the DUT presents a redirect or a read grant.
    always @(negedge clk) begin
        redir_t e;
        logic [31:0] r;
        if (redirect_valid) begin
            if (redir_q.size() == 0) check("redirect_spurious", {31'b0, redirect_valid}, 32'h0);
            else begin
                e = redir_q.pop_front();
                check("redirect_pc", redirect_pc, e.pc);
                check("redirect_cycle", cyc, e.due);
            end
        end
        if (ins_valid && ins_ready && ins_ren) begin
            if (rd_q.size() == 0) check("ins_read_spurious", {31'b0, ins_ready}, 32'h0);
            else begin
                r = rd_q.pop_front();
                check("ins_rdata", ins_rdata, r);
            end
        end
    end

    task automatic csr_op(input logic wen, input logic ren, input logic [11:0] addr,
                          input logic [31:0] wdata);
        logic [2:0] k;
        k = csr_idx(addr);
        if (ren) rd_q.push_back(m_csr[k[1:0]]);
        @(posedge clk); #1;
        ins_valid = 1'b1; ins_wen = wen; ins_ren = ren; ins_addr = addr; ins_wdata = wdata;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ins_ready) break;
        end
        check("ins_grant", {31'b0, ins_ready}, 32'h1);
        if (wen) m_csr[k[1:0]] = wdata;
        @(posedge clk); #1;
        ins_valid = 1'b0; ins_wen = $urandom; ins_ren = $urandom; ins_wdata = $urandom;
    endtask

    task automatic do_trap(input logic kind, input logic [31:0] pc, input logic [31:0] cause);
        logic [31:0] tgt;
        int          lat;
        int          bcnt;
        @(posedge clk); #1;
        trap_valid = 1'b1; trap_kind = kind; trap_pc = pc; trap_cause = cause;
        @(negedge clk);
        check("trap_ready", {31'b0, trap_ready}, 32'h1);
        if (!kind) begin
            tgt = model_target(m_csr[1], cause);
            m_csr[2] = pc;
            m_csr[3] = cause;
            m_csr[0] = model_entry(m_csr[0]);
            lat = 5;
        end else begin
            tgt = m_csr[2];
            m_csr[0] = model_mret(m_csr[0]);
            lat = 3;
        end
        redir_q.push_back('{pc: tgt, due: cyc + lat});
        @(posedge clk); #1;
        // Scramble the request fields: they must have been latched at accept.
        trap_valid = 1'b0; trap_kind = $urandom; trap_pc = $urandom; trap_cause = $urandom;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            bcnt++;
        end
        check("busy_cycles", bcnt, lat);
    endtask

    task automatic check_csrs();
        check("mstatus", csrf[0], m_csr[0]);
        check("mtvec", csrf[1], m_csr[1]);
        check("mepc", csrf[2], m_csr[2]);
        check("mcause", csrf[3], m_csr[3]);
    endtask

    logic [11:0] addr_tab [4] = '{12'h300, 12'h305, 12'h341, 12'h342};

    initial begin
        int          bad;
        logic [31:0] rc;
        // Reset with both requesters active: nothing may be granted or strobed.
        ins_valid = 1'b1; trap_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
        check("rst_ready", {30'b0, trap_ready, ins_ready}, 32'h0);
        check("rst_csr_strobes", {30'b0, csr_wen, csr_ren}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; ins_valid = 1'b0; trap_valid = 1'b0;
        @(negedge clk);
        check("idle_redirect_pc", redirect_pc, 32'h0);
        check("idle_trap_ready", {31'b0, trap_ready}, 32'h1);

        // Initialise CSRs through the instruction port.
        csr_op(1'b1, 1'b0, 12'h305, 32'h8000_0100);
        csr_op(1'b1, 1'b0, 12'h300, 32'h0000_1808);
        csr_op(1'b1, 1'b0, 12'h341, 32'h0);
        csr_op(1'b1, 1'b0, 12'h342, 32'h0);

        // ecall entry.
        do_trap(1'b0, 32'h8000_0040, 32'd11);
        check("ecall_mepc", csrf[2], 32'h8000_0040);
        check("ecall_mcause", csrf[3], 32'd11);
        check("ecall_mstatus", csrf[0], 32'h0000_1880);

        // mret.
        csr_op(1'b1, 1'b0, 12'h341, 32'h8000_0044);
        do_trap(1'b1, 32'h0, 32'h0);
        check("mret_mstatus", csrf[0], 32'h0000_1888);

        // Simultaneous trap and instruction: trap wins, instruction waits for IDLE.
        @(posedge clk); #1;
        ins_valid = 1'b1; ins_wen = 1'b1; ins_ren = 1'b0; ins_addr = 12'h305;
        ins_wdata = 32'h1234;
        trap_valid = 1'b1; trap_kind = 1'b1; trap_pc = 32'h0; trap_cause = 32'h0;
        @(negedge clk);
        check("arb_ins_ready", {31'b0, ins_ready}, 32'h0);
        check("arb_trap_ready", {31'b0, trap_ready}, 32'h1);
        redir_q.push_back('{pc: m_csr[2], due: cyc + 3});
        m_csr[0] = model_mret(m_csr[0]);
        @(posedge clk); #1;
        trap_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (ins_ready) bad++;
        end
        check("arb_ins_stalled", bad, 0);
        check("arb_ins_regrant", {31'b0, ins_ready}, 32'h1);
        m_csr[1] = 32'h1234;
        @(posedge clk); #1;
        ins_valid = 1'b0;
        @(negedge clk);
        check("arb_mtvec", csrf[1], 32'h1234);

        // csrrw pass-through: old value read in the grant cycle.
        csr_op(1'b1, 1'b0, 12'h341, 32'h10);
        csr_op(1'b1, 1'b1, 12'h341, 32'hDEAD);
        check("passthru_mepc", csrf[2], 32'hDEAD);

        // Reset during E_CAUSE: mepc committed, mcause untouched, no redirect.
        @(posedge clk); #1;
        trap_valid = 1'b1; trap_kind = 1'b0; trap_pc = 32'h1111_0000; trap_cause = 32'd5;
        @(negedge clk);
        @(posedge clk); #1;
        trap_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_wen", {31'b0, csr_wen}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_ready", {31'b0, trap_ready}, 32'h1);
        m_csr[2] = 32'h1111_0000;
        repeat (3) @(negedge clk);
        check_csrs();

        // Vectored-mode case (base only when the feature is compiled out).
        csr_op(1'b1, 1'b0, 12'h305, 32'h8000_0001);
        do_trap(1'b0, 32'h8000_0200, 32'h8000_0007);
        check_csrs();

        // Randomised mix of accesses and traps.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0, 1: csr_op($urandom, $urandom, addr_tab[$urandom_range(0, 3)], $urandom);
                2: begin
                    csr_op(1'b1, 1'b0, 12'h305, $urandom);
                    rc = $urandom;
                    if ($urandom_range(0, 1) == 1) rc = rc & 32'h8000_00ff;
                    do_trap(1'b0, $urandom, rc);
                end
                3: do_trap(1'b0, $urandom, $urandom_range(0, 15));
                default: do_trap(1'b1, $urandom, $urandom);
            endcase
            check_csrs();
        end

        repeat (4) @(negedge clk);
        check("redirect_queue_drained", redir_q.size(), 0);
        check("read_queue_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
                 pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
